// File: rtl/whackamole_pkg.sv
// Shared constants for the whack-a-mole seven-segment display: segment patterns,
// converter states and digit positions.
package whackamole_pkg;

   localparam int SCORE_W = 7;

   localparam logic [6:0] SEG_0     = 7'b1000000;
   localparam logic [6:0] SEG_1     = 7'b1111001;
   localparam logic [6:0] SEG_2     = 7'b0100100;
   localparam logic [6:0] SEG_3     = 7'b0110000;
   localparam logic [6:0] SEG_4     = 7'b0011001;
   localparam logic [6:0] SEG_5     = 7'b0010010;
   localparam logic [6:0] SEG_6     = 7'b0000010;
   localparam logic [6:0] SEG_7     = 7'b1111000;
   localparam logic [6:0] SEG_8     = 7'b0000000;
   localparam logic [6:0] SEG_9     = 7'b0010000;
   localparam logic [6:0] SEG_BLANK = 7'h7F;

   typedef enum logic [1:0] {IDLE, LOAD, SHIFT, STORE} conv_state_t;

   localparam logic [2:0] DIG_SC_ONES  = 3'd0;
   localparam logic [2:0] DIG_SC_TENS  = 3'd1;
   localparam logic [2:0] DIG_SC_HUNDS = 3'd2;
   localparam logic [2:0] DIG_TM_ONES  = 3'd6;
   localparam logic [2:0] DIG_TM_TENS  = 3'd7;

   function automatic logic [6:0] seg_encode(input logic [3:0] d);
      case (d)
         4'd0:    return SEG_0;
         4'd1:    return SEG_1;
         4'd2:    return SEG_2;
         4'd3:    return SEG_3;
         4'd4:    return SEG_4;
         4'd5:    return SEG_5;
         4'd6:    return SEG_6;
         4'd7:    return SEG_7;
         4'd8:    return SEG_8;
         4'd9:    return SEG_9;
         default: return SEG_BLANK;
      endcase
   endfunction

endpackage

// File: rtl/whackamole_sseg_display_if.sv
// Game-core to display bundle: game status in, multiplexed seven-segment drive out.
interface whackamole_sseg_display_if;
   import whackamole_pkg::*;

   logic               start_game;
   logic               game_timer_out;
   logic [SCORE_W-1:0] score;
   logic [7:0]         An;
   logic [6:0]         Seg;
   logic               Dp;

   modport master (output start_game, game_timer_out, score, input An, Seg, Dp);
   modport slave  (input start_game, game_timer_out, score, output An, Seg, Dp);
endinterface

// File: rtl/whackamole_sseg_display_bin2bcd_seq.sv
// Sequential 7-bit double-dabble converter; one conversion takes 10 cycles.
//  state | meaning
//  IDLE  | waiting for start
//  LOAD  | capture binary input, clear BCD accumulator
//  SHIFT | 7 add-3/shift steps
//  STORE | result valid on bcd, done asserted
module bin2bcd_seq
   import whackamole_pkg::*;
(
   input  logic        Clk,
   input  logic        Reset,
   input  logic        start,
   input  logic [6:0]  bin,
   output logic        done,
   output logic [11:0] bcd
);
   conv_state_t state, state_nxt;
   logic [18:0] sh, adj;
   logic [2:0]  shift_cnt;

   always_ff @(posedge Clk) begin
      if (Reset) state <= IDLE;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (start) state_nxt = LOAD;
         LOAD:    state_nxt = SHIFT;
         SHIFT:   if (shift_cnt == 3'd6) state_nxt = STORE;
         STORE:   state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      adj = sh;
      if (adj[10:7]  >= 4'd5) adj[10:7]  = adj[10:7]  + 4'd3;
      if (adj[14:11] >= 4'd5) adj[14:11] = adj[14:11] + 4'd3;
      if (adj[18:15] >= 4'd5) adj[18:15] = adj[18:15] + 4'd3;
   end

   always_ff @(posedge Clk) begin
      if (Reset) begin
         sh        <= '0;
         shift_cnt <= '0;
      end else begin
         case (state)
            LOAD: begin
               sh        <= {12'd0, bin};
               shift_cnt <= '0;
            end
            SHIFT: begin
               sh        <= {adj[17:0], 1'b0};
               shift_cnt <= shift_cnt + 3'd1;
            end
            default: ;
         endcase
      end
   end

   always_comb begin
      done = (state == STORE);
      bcd  = sh[18:7];
   end

endmodule

// File: rtl/whackamole_sseg_display.sv
// Countdown, shared BCD conversion and 8-digit scan for the game display.
// Leading-zero blanking is enabled by defining SSEG_LZ_BLANK_EN.
module whackamole_sseg_display
   import whackamole_pkg::*;
#(
   parameter int TICK_CYCLES  = 100000000,
   parameter int GAME_SECONDS = 60,
   parameter int SCAN_CYCLES  = 100000
) (
   input logic Clk,
   input logic Reset,
   whackamole_sseg_display_if.slave bus
);
   localparam int TW = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
   localparam int SW = (SCAN_CYCLES > 1) ? $clog2(SCAN_CYCLES) : 1;
   localparam logic [TW-1:0] TICK_LAST = TW'(TICK_CYCLES - 1);
   localparam logic [SW-1:0] SCAN_LAST = SW'(SCAN_CYCLES - 1);
   localparam logic [6:0]    SECS_INIT = 7'(GAME_SECONDS);

   logic [TW-1:0] tick_cnt;
   logic [SW-1:0] scan_cnt;
   logic [6:0]    secs_left, conv_in;
   logic          running, start_game_q, rise, src, conv_done;
   logic [11:0]   score_bcd, conv_bcd;
   logic [7:0]    time_bcd, an_q;
   logic [6:0]    seg_q;
   logic [2:0]    digit_sel;
   logic [3:0]    digit_val;
   logic          digit_on, lz_hund, lz_tens, lz_time;

   assign rise = bus.start_game & ~start_game_q;

   // game over wins over a simultaneous start edge
   always_ff @(posedge Clk) begin
      if (Reset) begin
         start_game_q <= 1'b0;
         secs_left    <= SECS_INIT;
         tick_cnt     <= '0;
         running      <= 1'b0;
      end else begin
         start_game_q <= bus.start_game;
         if (bus.game_timer_out) begin
            secs_left <= '0;
            running   <= 1'b0;
         end else if (rise) begin
            secs_left <= SECS_INIT;
            tick_cnt  <= '0;
            running   <= 1'b1;
         end else if (running) begin
            if (secs_left == 7'd0) begin
               running <= 1'b0;
            end else if (tick_cnt == TICK_LAST) begin
               tick_cnt  <= '0;
               secs_left <= secs_left - 7'd1;
               if (secs_left == 7'd1) running <= 1'b0;
            end else begin
               tick_cnt <= tick_cnt + 1'b1;
            end
         end
      end
   end

   assign conv_in = src ? secs_left : bus.score;

   bin2bcd_seq u_conv (
      .Clk   (Clk),
      .Reset (Reset),
      .start (1'b1),
      .bin   (conv_in),
      .done  (conv_done),
      .bcd   (conv_bcd)
   );

   always_ff @(posedge Clk) begin
      if (Reset) begin
         src       <= 1'b0;
         score_bcd <= '0;
         time_bcd  <= '0;
      end else if (conv_done) begin
         if (src) time_bcd  <= conv_bcd[7:0];
         else     score_bcd <= conv_bcd;
         src <= ~src;
      end
   end

`ifdef SSEG_LZ_BLANK_EN
   assign lz_hund = (score_bcd[11:8] == 4'd0);
   assign lz_tens = lz_hund && (score_bcd[7:4] == 4'd0);
   assign lz_time = (time_bcd[7:4] == 4'd0);
`else
   assign lz_hund = 1'b0;
   assign lz_tens = 1'b0;
   assign lz_time = 1'b0;
`endif

   always_comb begin
      digit_on  = 1'b0;
      digit_val = 4'd0;
      case (digit_sel)
         DIG_SC_ONES:  begin digit_on = 1'b1;     digit_val = score_bcd[3:0];  end
         DIG_SC_TENS:  begin digit_on = ~lz_tens; digit_val = score_bcd[7:4];  end
         DIG_SC_HUNDS: begin digit_on = ~lz_hund; digit_val = score_bcd[11:8]; end
         DIG_TM_ONES:  begin digit_on = 1'b1;     digit_val = time_bcd[3:0];   end
         DIG_TM_TENS:  begin digit_on = ~lz_time; digit_val = time_bcd[7:4];   end
         default: ;
      endcase
   end

   always_ff @(posedge Clk) begin
      if (Reset) begin
         scan_cnt  <= '0;
         digit_sel <= '0;
         an_q      <= 8'hFF;
         seg_q     <= SEG_BLANK;
      end else begin
         if (scan_cnt == SCAN_LAST) begin
            scan_cnt  <= '0;
            digit_sel <= digit_sel + 3'd1;
         end else begin
            scan_cnt <= scan_cnt + 1'b1;
         end
         an_q  <= digit_on ? ~(8'd1 << digit_sel) : 8'hFF;
         seg_q <= digit_on ? seg_encode(digit_val) : SEG_BLANK;
      end
   end

   assign bus.An  = an_q;
   assign bus.Seg = seg_q;
   assign bus.Dp  = 1'b1;

endmodule
